key_evt_sched: RTL and testbench

//  Event scheduler behind the key debouncer: takes NKEY debounced active-low key levels and

---
 rtl/key_evt_pkg.sv | 18 +
 rtl/key_evt_fifo.sv | 61 ++++++
 rtl/key_evt_sched.sv | 147 ++++++++++++++
 tb/tb_key_evt_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// Shared event encodings and sizing helper for the key event scheduler.
package key_evt_pkg;

  localparam int unsigned EVT_W = 2;

  typedef enum logic [EVT_W-1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_LONG    = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_type_e;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// First-word-fall-through event queue with occupancy count.
// The head output holds the last popped entry while the queue is empty.
module key_evt_fifo
  import key_evt_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 5,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] last;
  logic             do_push, do_pop;

  assign valid   = (cnt != '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  assign count   = cnt;
  assign dout    = valid ? mem[rptr] : last;

  // Storage write; contents need no reset since validity comes from cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers, occupancy and the held head value.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      last <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        rptr <= rptr + 1'b1;
        last <= mem[rptr];
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/key_evt_sched.sv
// Per-key PRESS/RELEASE/LONG/REPEAT event generation, pending flags,
// fixed-priority (lowest index first) arbitration into an event queue.
module key_evt_sched
  import key_evt_pkg::*;
#(
  parameter int unsigned NKEY     = 6,
  parameter int unsigned LONG_CNT = 1000,
  parameter int unsigned REP_CNT  = 200,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned KW   = idx_width(NKEY),
  localparam int unsigned CNTW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEY-1:0]  key_lvl,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [KW-1:0]    evt_key,
  output logic [1:0]       evt_type,
  output logic [CNTW-1:0]  evt_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int unsigned MAXC = (LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT;
  localparam int unsigned HW   = $clog2(MAXC + 1);

  logic [NKEY-1:0]  key_prev, long_st, long_nxt, pend, new_evt, lost, gnt_oh, grant;
  logic [EVT_W-1:0] ptype    [NKEY];
  logic [EVT_W-1:0] new_type [NKEY];
  logic [HW-1:0]    hold_cnt [NKEY];
  logic [HW-1:0]    cnt_nxt  [NKEY];
  logic [HW-1:0]    inc;
  logic             gnt_any, push, full;
  logic [KW-1:0]    gnt_idx;
  logic [EVT_W-1:0] gnt_type;
  logic [KW+EVT_W-1:0] head;

  // Edge detection and hold timing. LONG fires when the incremented count
  // reaches LONG_CNT-1 (LONG_CNT-1 cycles after PRESS); after that the count
  // restarts from 0 and REPEAT fires on reaching REP_CNT, so repeats are
  // spaced exactly REP_CNT cycles apart.
  always_comb begin
    new_evt  = '0;
    long_nxt = long_st;
    inc      = '0;
    for (int unsigned i = 0; i < NKEY; i++) begin
      new_type[i] = EVT_PRESS;
      cnt_nxt[i]  = hold_cnt[i];
      if (key_prev[i] && !key_lvl[i]) begin
        new_evt[i]  = 1'b1;
        new_type[i] = EVT_PRESS;
        cnt_nxt[i]  = '0;
        long_nxt[i] = 1'b0;
      end else if (!key_prev[i] && key_lvl[i]) begin
        new_evt[i]  = 1'b1;
        new_type[i] = EVT_RELEASE;
        cnt_nxt[i]  = '0;
        long_nxt[i] = 1'b0;
      end else if (!key_lvl[i]) begin
        inc = hold_cnt[i] + 1'b1;
        if (!long_st[i] && inc == HW'(LONG_CNT - 1)) begin
          new_evt[i]  = 1'b1;
          new_type[i] = EVT_LONG;
          cnt_nxt[i]  = '0;
          long_nxt[i] = 1'b1;
        end else if (long_st[i] && inc == HW'(REP_CNT)) begin
          new_evt[i]  = 1'b1;
          new_type[i] = EVT_REPEAT;
          cnt_nxt[i]  = '0;
        end else begin
          cnt_nxt[i] = inc;
        end
      end else begin
        cnt_nxt[i]  = '0;
        long_nxt[i] = 1'b0;
      end
    end
  end

  // Fixed-priority arbiter: lowest pending index wins when the queue has room.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_type = '0;
    gnt_oh   = '0;
    for (int unsigned i = 0; i < NKEY; i++) begin
      if (pend[i] && !gnt_any) begin
        gnt_any   = 1'b1;
        gnt_idx   = KW'(i);
        gnt_type  = ptype[i];
        gnt_oh[i] = 1'b1;
      end
    end
    push  = gnt_any & ~full;
    grant = push ? gnt_oh : '0;
    // A granted event leaves with this push, so a same-cycle new event is not a loss.
    lost  = new_evt & pend & ~grant;
  end

  // Per-key state, pending flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_prev <= '1;
      long_st  <= '0;
      pend     <= '0;
      ovf      <= 1'b0;
      for (int unsigned i = 0; i < NKEY; i++) begin
        hold_cnt[i] <= '0;
        ptype[i]    <= EVT_PRESS;
      end
    end else begin
      key_prev <= key_lvl;
      long_st  <= long_nxt;
      for (int unsigned i = 0; i < NKEY; i++) begin
        hold_cnt[i] <= cnt_nxt[i];
        if (new_evt[i]) begin
          pend[i]  <= 1'b1;
          ptype[i] <= new_type[i];
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (|lost)        ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  key_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (KW + EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({gnt_idx, gnt_type}),
    .full  (full),
    .pop   (evt_ready),
    .valid (evt_valid),
    .dout  (head),
    .count (evt_cnt)
  );

  assign evt_key  = head[KW+EVT_W-1:EVT_W];
  assign evt_type = head[EVT_W-1:0];

endmodule

// File: tb/tb_key_evt_sched.sv
// Directed self-checking bench for key_evt_sched (NKEY=6, LONG=8, REP=4, DEPTH=4).
module tb_key_evt_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] key_lvl;
  logic       evt_valid;
  logic       evt_ready;
  logic [2:0] evt_key;
  logic [1:0] evt_type;
  logic [2:0] evt_cnt;
  logic       ovf;
  logic       ovf_clr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int key;
    int typ;
  } mon_t;
  mon_t mon_q[$];
  int   exp_q[$];

  typedef struct {
    logic [5:0] lvl;
    logic       v;
    int         k;
    int         t;
    int         c;
    logic       o;
  } vec_t;
  vec_t tbl[14];

  key_evt_sched #(
    .NKEY     (6),
    .LONG_CNT (8),
    .REP_CNT  (4),
    .DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_lvl   (key_lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_key   (evt_key),
    .evt_type  (evt_type),
    .evt_cnt   (evt_cnt),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Cycle stamp for event timing.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready)
      mon_q.push_back('{cyc: cyc, key: int'(evt_key), typ: int'(evt_type)});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic v, input int k, input int t,
                         input int c, input logic o);
    check({nm, ".valid"}, int'(evt_valid), int'(v));
    if (v) begin
      check({nm, ".key"},  int'(evt_key),  k);
      check({nm, ".type"}, int'(evt_type), t);
    end
    check({nm, ".cnt"}, int'(evt_cnt), c);
    check({nm, ".ovf"}, int'(ovf), int'(o));
  endtask

  // Compare recorded events (key*4+type) against exp_q.
  task automatic cmp_list(input string nm);
    check({nm, ".n"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < mon_q.size())
        check($sformatf("%s.ev%0d", nm, i), mon_q[i].key * 4 + mon_q[i].typ, exp_q[i]);
    end
  endtask

  initial begin
    // Cycle table for the all-keys-at-once case, including a release landing on
    // the same cycle key5's pending PRESS is granted.
    tbl[0] = '{6'h00, 1'b0, 0, 0, 0, 1'b0};
    for (int i = 1; i <= 5; i++) tbl[i] = '{6'h00, 1'b1, i - 1, 0, 1, 1'b0};
    tbl[6] = '{6'h3F, 1'b1, 5, 0, 1, 1'b0};
    for (int i = 7; i <= 12; i++) tbl[i] = '{6'h3F, 1'b1, i - 7, 1, 1, 1'b0};
    tbl[13] = '{6'h3F, 1'b0, 5, 1, 0, 1'b0};

    rst = 1'b1; key_lvl = 6'h3F; evt_ready = 1'b1; ovf_clr = 1'b0;
    tick(3);
    check("rst.valid", int'(evt_valid), 0);
    check("rst.key",   int'(evt_key),   0);
    check("rst.type",  int'(evt_type),  0);
    check("rst.cnt",   int'(evt_cnt),   0);
    check("rst.ovf",   int'(ovf),       0);
    rst = 1'b0;
    tick(2);

    // 1: short press/release on key0, two-cycle latency each way
    key_lvl = 6'h3E;
    tick(1); chk_out("t1.k",  1'b0, 0, 0, 0, 1'b0);
    tick(1); chk_out("t1.k1", 1'b1, 0, 0, 1, 1'b0);
    key_lvl = 6'h3F;
    tick(1); chk_out("t1.k2", 1'b0, 0, 0, 0, 1'b0);
    tick(1); chk_out("t1.k3", 1'b1, 0, 1, 1, 1'b0);
    tick(1); chk_out("t1.k4", 1'b0, 0, 1, 0, 1'b0);
    tick(3);

    // 2: hold key2 for 20 cycles
    mon_q.delete(); exp_q.delete();
    key_lvl = 6'h3B;
    tick(20);
    key_lvl = 6'h3F;
    tick(10);
    exp_q = '{8, 10, 11, 11, 11, 9};
    cmp_list("t2");
    if (mon_q.size() >= 6) begin
      check("t2.gapL",  mon_q[1].cyc - mon_q[0].cyc, 7);
      check("t2.gapR1", mon_q[2].cyc - mon_q[1].cyc, 4);
      check("t2.gapR2", mon_q[3].cyc - mon_q[2].cyc, 4);
      check("t2.gapR3", mon_q[4].cyc - mon_q[3].cyc, 4);
      check("t2.gapRel", mon_q[5].cyc - mon_q[4].cyc, 1);
    end

    // 3: all keys pressed together, then released together
    for (int i = 0; i < 14; i++) begin
      key_lvl = tbl[i].lvl;
      tick(1);
      chk_out($sformatf("t3.r%0d", i), tbl[i].v, tbl[i].k, tbl[i].t, tbl[i].c, tbl[i].o);
    end
    tick(3);

    // 4: stalled consumer, queue saturates, overwrite on key4 sets ovf
    mon_q.delete(); exp_q.delete();
    evt_ready = 1'b0;
    key_lvl   = 6'h20;
    tick(5);
    chk_out("t4.full", 1'b1, 0, 0, 4, 1'b0);
    key_lvl = 6'h30;
    tick(1);
    chk_out("t4.ovf", 1'b1, 0, 0, 4, 1'b1);
    key_lvl = 6'h3F;
    tick(1);
    check("t4.hold.cnt", int'(evt_cnt), 4);
    evt_ready = 1'b1;
    tick(15);
    exp_q = '{0, 4, 8, 12, 1, 5, 9, 13, 17};
    cmp_list("t4");
    check("t4.sticky", int'(ovf), 1);
    check("t4.empty", int'(evt_cnt), 0);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("t4.clr", int'(ovf), 0);
    tick(2);

    // 5: pop while full blocks the push for one cycle
    mon_q.delete(); exp_q.delete();
    evt_ready = 1'b0;
    key_lvl   = 6'h20;
    tick(5);
    check("t5.full", int'(evt_cnt), 4);
    evt_ready = 1'b1;
    tick(1);
    check("t5.pop.cnt", int'(evt_cnt), 3);
    check("t5.pop.key", int'(evt_key), 1);
    evt_ready = 1'b0;
    key_lvl   = 6'h3F;
    tick(1);
    check("t5.push.cnt", int'(evt_cnt), 4);
    evt_ready = 1'b1;
    tick(15);
    exp_q = '{0, 4, 8, 12, 16, 1, 5, 9, 13, 17};
    cmp_list("t5");
    check("t5.ovf", int'(ovf), 0);
    check("t5.empty", int'(evt_cnt), 0);

    // 6: reset mid-operation with key1 held
    evt_ready = 1'b0;
    key_lvl   = 6'h38;
    tick(4);
    check("t6.pre.cnt", int'(evt_cnt), 3);
    key_lvl = 6'h3D;
    rst     = 1'b1;
    tick(1);
    check("t6.rst.valid", int'(evt_valid), 0);
    check("t6.rst.cnt",   int'(evt_cnt),   0);
    check("t6.rst.key",   int'(evt_key),   0);
    check("t6.rst.type",  int'(evt_type),  0);
    check("t6.rst.ovf",   int'(ovf),       0);
    rst = 1'b0;
    tick(1); chk_out("t6.a", 1'b0, 0, 0, 0, 1'b0);
    tick(1); chk_out("t6.b", 1'b1, 1, 0, 1, 1'b0);
    tick(2); chk_out("t6.c", 1'b1, 1, 0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
